neuron_pipeline_sched: RTL and testbench

//  Sequencer for the time-multiplexed neuron/synapse pipeline (Iz_neuron, synapse RAM banks).

---
 rtl/neuron_pipeline_sched.sv | 104 ++++++++++
 tb/tb_neuron_pipeline_sched.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_pipeline_sched.sv
// rtl/neuron_pipeline_sched.sv - frame sequencer for the time-multiplexed neuron/synapse pipeline
// Optional freeze input enabled by defining NEURON_SCHED_STALL_EN.
module neuron_pipeline_sched #(
    parameter int NN      = 8,
    parameter int FRAME_W = 32
) (
    input  logic               neuron_clk,
    input  logic               reset_sim,
    input  logic               run,
    input  logic               step,
`ifdef NEURON_SCHED_STALL_EN
    input  logic               stall,
`endif
    output logic               busy,
    output logic [NN+2:0]      neuron_counter,
    output logic [NN:0]        neuron_index,
    output logic [1:0]         phase,
    output logic               neuron_write_count,
    output logic               read_clock,
    output logic               write_enable,
    output logic               data_valid,
    output logic               frame_done,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int CW = NN + 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [FRAME_W-1:0] fc_q, fc_d;
    logic               hold;
    logic               cnt_last;
    logic               strobe_en;

`ifdef NEURON_SCHED_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign cnt_last  = &cnt_q;
    assign busy      = (state_q != S_IDLE);
    // A stalled cycle must not look like a RAM access or a frame marker downstream.
    assign strobe_en = busy & ~hold;

    always_ff @(posedge neuron_clk) begin
        if (reset_sim) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fc_q    <= fc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fc_d    = fc_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (run) begin
                    state_d = S_RUN;
                end else if (step) begin
                    state_d = S_LAST;
                end
            end
            S_RUN, S_LAST: begin
                if (!hold) begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    // Frame boundary: the only point where the sequencer may stop or be promoted.
                    if (cnt_last) begin
                        fc_d    = fc_q + {{(FRAME_W-1){1'b0}}, 1'b1};
                        state_d = run ? S_RUN : S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign neuron_counter     = cnt_q;
    assign neuron_index       = cnt_q[CW-1:2];
    assign phase              = cnt_q[1:0];
    assign neuron_write_count = strobe_en & (cnt_q[1:0] == 2'd0);
    assign read_clock         = strobe_en & (cnt_q[1:0] == 2'd1);
    assign write_enable       = strobe_en & (cnt_q[1:0] == 2'd3);
    assign data_valid         = strobe_en & (cnt_q == '0);
    assign frame_done         = strobe_en & cnt_last;
    assign frame_count        = fc_q;

endmodule

// File: tb/tb_neuron_pipeline_sched.sv
// tb/tb_neuron_pipeline_sched.sv - scoreboard bench for neuron_pipeline_sched with NN=1 (16-cycle frames)
// Exercises the stall path when built with NEURON_SCHED_STALL_EN.
module tb_neuron_pipeline_sched;

    logic        clk = 1'b0;
    logic        reset_sim;
    logic        run;
    logic        step;
    logic        stall_r;
    logic        busy;
    logic [3:0]  neuron_counter;
    logic [1:0]  neuron_index;
    logic [1:0]  phase;
    logic        neuron_write_count;
    logic        read_clock;
    logic        write_enable;
    logic        data_valid;
    logic        frame_done;
    logic [31:0] frame_count;

    typedef struct packed {
        logic        busy;
        logic        stall;
        logic [3:0]  cnt;
        logic [31:0] fc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] fc_exp = 0;

    always #5 clk = ~clk;

    neuron_pipeline_sched #(.NN(1), .FRAME_W(32)) dut (
        .neuron_clk         (clk),
        .reset_sim          (reset_sim),
        .run                (run),
        .step               (step),
`ifdef NEURON_SCHED_STALL_EN
        .stall              (stall_r),
`endif
        .busy               (busy),
        .neuron_counter     (neuron_counter),
        .neuron_index       (neuron_index),
        .phase              (phase),
        .neuron_write_count (neuron_write_count),
        .read_clock         (read_clock),
        .write_enable       (write_enable),
        .data_valid         (data_valid),
        .frame_done         (frame_done),
        .frame_count        (frame_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Drive this cycle's inputs and queue the outputs expected during this cycle.
    task automatic tk(input logic r, input logic s, input logic rst, input logic st,
                      input logic eb, input logic [3:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        run       = r;
        step      = s;
        reset_sim = rst;
        stall_r   = st;
        e.busy    = eb;
        e.stall   = st;
        e.cnt     = ec;
        e.fc      = fc_exp;
        exp_q.push_back(e);
    endtask

    task automatic monitor();
        exp_t       e;
        logic       en;
        logic [4:0] strb_exp;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                en = e.busy & ~e.stall;
                strb_exp = {en & (e.cnt[1:0] == 2'd0), en & (e.cnt[1:0] == 2'd1),
                            en & (e.cnt[1:0] == 2'd3), en & (e.cnt == 4'd0),
                            en & (e.cnt == 4'd15)};
                chk("busy", 64'(busy), 64'(e.busy));
                chk("counter", 64'({neuron_counter, neuron_index, phase}),
                    64'({e.cnt, e.cnt[3:2], e.cnt[1:0]}));
                chk("frame_count", 64'(frame_count), 64'(e.fc));
                chk("strobes", 64'({neuron_write_count, read_clock, write_enable, data_valid, frame_done}),
                    64'(strb_exp));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_sim = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        stall_r   = 1'b0;
        fork
            monitor();
        join_none

        // reset held with step pulsing: ignored
        repeat (3) tk(0, 1, 1, 0, 0, 4'd0);
        tk(0, 0, 0, 0, 0, 4'd0);
        tk(0, 0, 0, 0, 0, 4'd0);

        // continuous run: two back-to-back frames, run dropped at start of second
        tk(1, 0, 0, 0, 0, 4'd0);
        for (int k = 1; k <= 16; k++) tk(1, 0, 0, 0, 1, 4'(k - 1));
        fc_exp = 1;
        for (int k = 17; k <= 32; k++) tk(0, 0, 0, 0, 1, 4'(k - 17));
        fc_exp = 2;
        tk(0, 0, 0, 0, 0, 4'd0);

        // single step, second step while busy is ignored
        tk(0, 1, 0, 0, 0, 4'd0);
        for (int k = 1; k <= 16; k++) tk(0, k == 5, 0, 0, 1, 4'(k - 1));
        fc_exp = 3;
        tk(0, 0, 0, 0, 0, 4'd0);
        tk(0, 0, 0, 0, 0, 4'd0);

        // run dropped at counter 5: frame completes
        tk(1, 0, 0, 0, 0, 4'd0);
        for (int k = 1; k <= 16; k++) tk(k < 6, 0, 0, 0, 1, 4'(k - 1));
        fc_exp = 4;
        tk(0, 0, 0, 0, 0, 4'd0);
        tk(0, 0, 0, 0, 0, 4'd0);

        // reset at counter 7 with run held high
        tk(1, 0, 0, 0, 0, 4'd0);
        for (int k = 1; k <= 8; k++) tk(1, 0, k == 8, 0, 1, 4'(k - 1));
        fc_exp = 0;
        tk(1, 0, 0, 0, 0, 4'd0);
        tk(1, 0, 0, 0, 1, 4'd0);
        for (int k = 11; k <= 25; k++) tk(k <= 12, 0, 0, 0, 1, 4'(k - 10));
        fc_exp = 1;
        tk(0, 0, 0, 0, 0, 4'd0);

`ifdef NEURON_SCHED_STALL_EN
        // stall in idle has no effect
        tk(0, 0, 0, 1, 0, 4'd0);
        tk(0, 0, 0, 0, 0, 4'd0);
        // stall for 3 cycles at counter 9
        tk(1, 0, 0, 0, 0, 4'd0);
        for (int k = 1; k <= 9; k++) tk(k < 3, 0, 0, 0, 1, 4'(k - 1));
        repeat (3) tk(0, 0, 0, 1, 1, 4'd9);
        tk(0, 0, 0, 0, 1, 4'd9);
        for (int v = 10; v <= 15; v++) tk(0, 0, 0, 0, 1, 4'(v));
        fc_exp = 2;
        tk(0, 0, 0, 0, 0, 4'd0);
        tk(0, 0, 0, 0, 0, 4'd0);
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain %0d expectations left, required 0", exp_q.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
